chip8_display_reader: RTL and testbench

// - Read side of the chip-8 framebuffer. Walks a 64x32 chip-8 display scaled onto the HDMI raster.
// - Issues pixel_x/pixel_y requests to chip8_video and maps each returned bit to a 24-bit colour.
// - Drives the ad (buffer-swap enable) line back to chip8_video during vertical blank.
// - Sits between the video timing generator and the TMDS encoders; sync signals are delayed to match.

---
 rtl/chip8_pkg.sv | 9 +
 rtl/pipeline.sv | 36 +++
 rtl/chip8_display_reader.sv | 171 +++++++++++++++++
 tb/tb_chip8_display_reader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
// Shared chip-8 display constants and types for the framebuffer read path.
package chip8_pkg;
    localparam int CHIP8_W = 64;
    localparam int CHIP8_H = 32;

    typedef logic [23:0] rgb_t;
    typedef logic [5:0]  c8_x_t;
    typedef logic [4:0]  c8_y_t;
endpackage

// File: rtl/pipeline.sv
// Generic fixed-depth delay line, flushed to zero by reset.
module pipeline #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    // Next-state of every stage: shift by one.
    always_comb begin
        stage_d[0] = data_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign data_out = stage_q[DEPTH-1];
endmodule

// File: rtl/chip8_display_reader.sv
// Read side of the chip-8 framebuffer: walks the 64x32 image scaled onto the
// HDMI raster, requests each bit and turns it into a colour aligned with the syncs.
module chip8_display_reader
    import chip8_pkg::*;
#(
    parameter int SCALE    = 20,
    parameter int H_OFFSET = 0,
    parameter int V_OFFSET = 40,
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int RD_LAT   = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        active_draw_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        new_frame_in,
    input  logic        pixel_in,
    input  logic [23:0] light_color_in,
    input  logic [23:0] dark_color_in,
    input  logic [23:0] border_color_in,
    output logic [5:0]  pixel_x_out,
    output logic [4:0]  pixel_y_out,
    output logic        ad_out,
    output logic [7:0]  red_out,
    output logic [7:0]  green_out,
    output logic [7:0]  blue_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        active_out
);
    localparam int LAT        = RD_LAT + 2;
    localparam int FLAG_DEPTH = RD_LAT + 1;
    localparam int SUB_W      = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [10:0]      H_START  = 11'(H_OFFSET);
    localparam logic [10:0]      H_END    = 11'(H_OFFSET + CHIP8_W * SCALE);
    localparam logic [10:0]      H_LIMIT  = 11'(H_ACTIVE);
    localparam logic [9:0]       V_START  = 10'(V_OFFSET);
    localparam logic [9:0]       V_END    = 10'(V_OFFSET + CHIP8_H * SCALE);
    localparam logic [9:0]       V_BLANK  = 10'(V_ACTIVE);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);
    localparam c8_x_t            X_LAST   = 6'(CHIP8_W - 1);
    localparam c8_y_t            Y_LAST   = 5'(CHIP8_H - 1);

    c8_x_t            px_q, px_d, px_base_s;
    c8_y_t            py_q, py_d, py_base_s;
    logic [SUB_W-1:0] sub_x_q, sub_x_d, sub_x_base_s;
    logic [SUB_W-1:0] sub_y_q, sub_y_d, sub_y_base_s;
    logic             line_win_q, line_win_d, line_win_base_s;
    logic             synced_q, synced_d;
    logic             ad_q, ad_d;
    rgb_t             rgb_q, rgb_d;
    logic [1:0]       flag_q [FLAG_DEPTH];
    logic [1:0]       flag_d [FLAG_DEPTH];
    logic             in_win_s;
    logic [2:0]       sync_pipe_s;

    assign in_win_s = active_draw_in
                   && (hcount_in >= H_START) && (hcount_in < H_END) && (hcount_in < H_LIMIT)
                   && (vcount_in >= V_START) && (vcount_in < V_END);

    // Scaled walk: a frame start clears everything before this pixel's own rules apply.
    always_comb begin
        synced_d = synced_q | new_frame_in;
        ad_d     = synced_d && (vcount_in >= V_BLANK);
        if (new_frame_in) begin
            px_base_s = 6'd0;  sub_x_base_s = '0;
            py_base_s = 5'd0;  sub_y_base_s = '0;
            line_win_base_s = 1'b0;
        end else begin
            px_base_s = px_q;  sub_x_base_s = sub_x_q;
            py_base_s = py_q;  sub_y_base_s = sub_y_q;
            line_win_base_s = line_win_q;
        end

        if (hcount_in == H_START) begin
            px_d = 6'd0;  sub_x_d = '0;
        end else if (in_win_s && (sub_x_base_s == SUB_LAST)) begin
            sub_x_d = '0;
            px_d    = (px_base_s == X_LAST) ? px_base_s : px_base_s + 6'd1;
        end else if (in_win_s) begin
            px_d = px_base_s;  sub_x_d = sub_x_base_s + SUB_W'(1);
        end else begin
            px_d = px_base_s;  sub_x_d = sub_x_base_s;
        end

        // Rows advance once per line, at its first hcount, if the line before touched the window.
        if (hcount_in != 11'd0) begin
            py_d = py_base_s;  sub_y_d = sub_y_base_s;
            line_win_d = line_win_base_s | in_win_s;
        end else if (vcount_in == V_START) begin
            py_d = 5'd0;  sub_y_d = '0;
            line_win_d = in_win_s;
        end else if (line_win_base_s && (sub_y_base_s == SUB_LAST)) begin
            sub_y_d = '0;
            py_d    = (py_base_s == Y_LAST) ? py_base_s : py_base_s + 5'd1;
            line_win_d = in_win_s;
        end else if (line_win_base_s) begin
            py_d = py_base_s;  sub_y_d = sub_y_base_s + SUB_W'(1);
            line_win_d = in_win_s;
        end else begin
            py_d = py_base_s;  sub_y_d = sub_y_base_s;
            line_win_d = in_win_s;
        end
    end

    // Carries {active, show-framebuffer} alongside the read until pixel_in is valid.
    always_comb begin
        flag_d[0] = {active_draw_in, in_win_s && synced_d};
        for (int i = 1; i < FLAG_DEPTH; i++) begin
            flag_d[i] = flag_q[i-1];
        end
    end

    // Colour select once the requested bit has returned.
    always_comb begin
        if (!flag_q[FLAG_DEPTH-1][1]) begin
            rgb_d = 24'h000000;
        end else if (flag_q[FLAG_DEPTH-1][0]) begin
            rgb_d = pixel_in ? light_color_in : dark_color_in;
        end else begin
            rgb_d = border_color_in;
        end
    end

    // All state and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            px_q <= 6'd0;  sub_x_q <= '0;
            py_q <= 5'd0;  sub_y_q <= '0;
            line_win_q <= 1'b0;
            synced_q   <= 1'b0;
            ad_q       <= 1'b0;
            rgb_q      <= 24'h000000;
            for (int i = 0; i < FLAG_DEPTH; i++) begin
                flag_q[i] <= 2'b00;
            end
        end else begin
            px_q <= px_d;  sub_x_q <= sub_x_d;
            py_q <= py_d;  sub_y_q <= sub_y_d;
            line_win_q <= line_win_d;
            synced_q   <= synced_d;
            ad_q       <= ad_d;
            rgb_q      <= rgb_d;
            for (int i = 0; i < FLAG_DEPTH; i++) begin
                flag_q[i] <= flag_d[i];
            end
        end
    end

    pipeline #(.WIDTH(3), .DEPTH(LAT)) u_sync_pipe (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .data_in  ({hsync_in, vsync_in, active_draw_in}),
        .data_out (sync_pipe_s)
    );

    assign pixel_x_out = px_q;
    assign pixel_y_out = py_q;
    assign ad_out      = ad_q;
    assign red_out     = rgb_q[23:16];
    assign green_out   = rgb_q[15:8];
    assign blue_out    = rgb_q[7:0];
    assign hsync_out   = sync_pipe_s[2];
    assign vsync_out   = sync_pipe_s[1];
    assign active_out  = sync_pipe_s[0];
endmodule

// File: tb/tb_chip8_display_reader.sv
// Bench for chip8_display_reader: abbreviated raster lines, a modelled chip8_video
// framebuffer, and a per-cycle reference computed from hcount/vcount arithmetic.
module tb_chip8_display_reader;
    localparam int SCALE    = 20;
    localparam int H_OFFSET = 0;
    localparam int V_OFFSET = 40;
    localparam int H_ACTIVE = 1280;
    localparam int V_ACTIVE = 720;
    localparam int RD_LAT   = 1;
    localparam int LAT      = RD_LAT + 2;
    localparam int V_TOTAL  = 750;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        active_draw_in, hsync_in, vsync_in, new_frame_in, pixel_in;
    logic [23:0] light_color_in, dark_color_in, border_color_in;
    logic [5:0]  pixel_x_out;
    logic [4:0]  pixel_y_out;
    logic        ad_out, hsync_out, vsync_out, active_out;
    logic [7:0]  red_out, green_out, blue_out;

    int n_cmp = 0;
    int n_bad = 0;
    int frame_id = 0;
    bit fb [32][64];

    typedef struct {
        int h; int v; int fid;
        bit act; bit hs; bit vs; bit rst; bit syn;
    } samp_t;
    samp_t hist [8];

    always #5 clk = ~clk;

    chip8_display_reader #(
        .SCALE(SCALE), .H_OFFSET(H_OFFSET), .V_OFFSET(V_OFFSET),
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .RD_LAT(RD_LAT)
    ) dut (
        .clk_in(clk), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .active_draw_in(active_draw_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .new_frame_in(new_frame_in), .pixel_in(pixel_in),
        .light_color_in(light_color_in), .dark_color_in(dark_color_in),
        .border_color_in(border_color_in),
        .pixel_x_out(pixel_x_out), .pixel_y_out(pixel_y_out), .ad_out(ad_out),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .active_out(active_out)
    );

    function automatic bit in_window(int h, int v, bit act);
        return act && h >= H_OFFSET && h < H_OFFSET + 64 * SCALE
                   && v >= V_OFFSET && v < V_OFFSET + 32 * SCALE;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, got, want, $time);
        end
    endtask

    initial begin : param_check
        if (H_OFFSET + 64 * SCALE > H_ACTIVE || V_OFFSET + 32 * SCALE > V_ACTIVE || SCALE < 1) begin
            $display("FAIL params: chip-8 window lies outside the raster");
            $fatal(1, "illegal parameters");
        end
    end

    // chip8_video stand-in: returns the addressed bit RD_LAT (=1) cycle after the request.
    initial begin : video_emu
        logic [5:0] x_prev;
        logic [4:0] y_prev;
        x_prev = 6'd0;
        y_prev = 5'd0;
        pixel_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pixel_in = fb[y_prev][x_prev];
            x_prev = pixel_x_out;
            y_prev = pixel_y_out;
        end
    end

    // Reference model and the single compare process.
    initial begin : compare
        samp_t s, m;
        bit syn_m, any_rst;
        int n, cx, cy;
        logic [23:0] lc, dc, bc;
        logic [31:0] exp_rgb;
        int ch [4];
        int cv [4];
        ch = '{0, 1279, 0, 1279};
        cv = '{40, 40, 679, 679};
        syn_m = 1'b0;
        n = 8;
        for (int i = 0; i < 8; i++) begin
            hist[i].h = 0; hist[i].v = 0; hist[i].fid = 0;
            hist[i].act = 1'b0; hist[i].hs = 1'b0; hist[i].vs = 1'b0;
            hist[i].rst = 1'b1; hist[i].syn = 1'b0;
        end
        forever begin
            @(posedge clk);
            s.h = int'(hcount_in); s.v = int'(vcount_in); s.fid = frame_id;
            s.act = active_draw_in; s.hs = hsync_in; s.vs = vsync_in; s.rst = rst_in;
            s.syn = !rst_in && (syn_m || new_frame_in);
            syn_m = s.syn;
            lc = light_color_in; dc = dark_color_in; bc = border_color_in;
            n++;
            hist[n % 8] = s;
            @(negedge clk);

            // one-cycle outputs
            chk("ad", 32'(ad_out), 32'(!s.rst && s.syn && s.v >= V_ACTIVE));
            if (s.rst) begin
                chk("px_rst", 32'(pixel_x_out), 32'd0);
                chk("py_rst", 32'(pixel_y_out), 32'd0);
            end else if (s.syn && in_window(s.h, s.v, s.act)) begin
                chk("px", 32'(pixel_x_out), 32'((s.h - H_OFFSET) / SCALE));
                chk("py", 32'(pixel_y_out), 32'((s.v - V_OFFSET) / SCALE));
            end
            if (!s.rst && s.syn && s.h == 0 && s.v == 720) chk("ad_rise", 32'(ad_out), 32'd1);
            if (!s.rst && s.syn && s.h == 20 && s.v == 40) chk("px_h20", 32'(pixel_x_out), 32'd1);
            if (!s.rst && s.syn && s.h == 19 && s.v == 40) chk("px_h19", 32'(pixel_x_out), 32'd0);
            if (!s.rst && s.syn && s.h == 1279 && s.v == 40) chk("px_h1279", 32'(pixel_x_out), 32'd63);
            if (!s.rst && s.syn && s.h == 0 && s.v == 59) chk("py_v59", 32'(pixel_y_out), 32'd0);
            if (!s.rst && s.syn && s.h == 0 && s.v == 60) chk("py_v60", 32'(pixel_y_out), 32'd1);
            if (!s.rst && s.syn && s.h == 0 && s.v == 679) chk("py_v679", 32'(pixel_y_out), 32'd31);

            // LAT-cycle outputs
            any_rst = 1'b0;
            for (int k = 0; k < LAT; k++) any_rst = any_rst | hist[(n - k) % 8].rst;
            m = hist[(n - LAT + 1) % 8];
            if (any_rst || !m.act) begin
                exp_rgb = 32'h0;
            end else if (m.syn && in_window(m.h, m.v, m.act)) begin
                cx = (m.h - H_OFFSET) / SCALE;
                cy = (m.v - V_OFFSET) / SCALE;
                exp_rgb = fb[cy][cx] ? 32'(lc) : 32'(dc);
            end else begin
                exp_rgb = 32'(bc);
            end
            chk("rgb", 32'({red_out, green_out, blue_out}), exp_rgb);
            chk("hsync", 32'(hsync_out), 32'(!any_rst && m.hs));
            chk("vsync", 32'(vsync_out), 32'(!any_rst && m.vs));
            chk("active", 32'(active_out), 32'(!any_rst && m.act));
            if (!any_rst && m.syn && m.fid >= 1) begin
                for (int j = 0; j < 4; j++) begin
                    if (m.h == ch[j] && m.v == cv[j])
                        chk("corner", 32'({red_out, green_out, blue_out}),
                            (j == m.fid - 1) ? 32'h00FFFFFF : 32'h00000000);
                end
            end
        end
    end

    task automatic cyc(int h, int v, bit act, bit nf, bit rst);
        hcount_in      = 11'(h);
        vcount_in      = 10'(v);
        active_draw_in = act;
        new_frame_in   = nf;
        rst_in         = rst;
        hsync_in       = 1'($urandom_range(0, 1));
        vsync_in       = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    // Full lines walk every active hcount; short lines only touch hcount 0..1.
    task automatic run_line(int v, bit full, int rst_h);
        int last;
        last = full ? H_ACTIVE - 1 : 1;
        for (int h = 0; h <= last; h++) cyc(h, v, v < V_ACTIVE, h == 0 && v == 0, h == rst_h);
        for (int h = H_ACTIVE; h < H_ACTIVE + 4; h++) cyc(h, v, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_frame(int f0, int f1, int f2, int f3, int rst_v);
        for (int v = 0; v < V_TOTAL; v++)
            run_line(v, v == f0 || v == f1 || v == f2 || v == f3, (v == rst_v) ? 1 : -1);
    endtask

    task automatic set_checker();
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 64; x++) fb[y][x] = ((x + y) % 2) == 0;
    endtask

    task automatic set_single(int x, int y);
        for (int yy = 0; yy < 32; yy++)
            for (int xx = 0; xx < 64; xx++) fb[yy][xx] = 1'b0;
        fb[y][x] = 1'b1;
    endtask

    initial begin : stimulus
        int cx [4];
        int cy [4];
        cx = '{0, 63, 0, 63};
        cy = '{0, 0, 31, 31};
        light_color_in  = 24'hFFFFFF;
        dark_color_in   = 24'h000000;
        border_color_in = 24'h123456;
        set_checker();
        for (int i = 0; i < 4; i++) cyc(1281, 745, 1'b0, 1'b0, 1'b1);
        for (int v = 746; v < V_TOTAL; v++) run_line(v, 1'b0, -1);

        run_frame(40, 60, 100, 679, -1);
        for (int k = 0; k < 4; k++) begin
            set_single(cx[k], cy[k]);
            frame_id = k + 1;
            run_frame(40, 679, -1, -1, -1);
        end

        frame_id = 0;
        set_checker();
        border_color_in = 24'h00FF00;
        light_color_in  = 24'hC0FFEE;
        dark_color_in   = 24'h202020;
        run_frame(-1, -1, -1, -1, 300);
        run_frame(40, 100, -1, -1, -1);
        for (int i = 0; i < 8; i++) cyc(1281, 745, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
